// File: rtl/bsg_counter_window_sched_pkg.sv
// Shared perf-monitor definitions: scheduler state encoding and index-width helper.
package bsg_counter_window_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } sched_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up_sat_async.sv
// Clear/up event counter that saturates at all-ones; clear has priority over up.
module bsg_counter_clear_up_sat_async #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  function automatic logic [width_p-1:0] sat_inc(input logic [width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (up_i) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bsg_counter_window_sched.sv
// Round-robin window scheduler: counts one channel's events per window on a
// shared saturating counter and reports {chan, count} over valid/ready.
module bsg_counter_window_sched
  import bsg_counter_window_sched_pkg::*;
#(
  parameter int num_chan_p = 4,
  parameter int width_p    = 8,
  parameter int window_p   = 128
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             en_i,
  input  logic [num_chan_p-1:0]            ev_i,
  output logic                             v_o,
  input  logic                             ready_i,
  output logic [idx_w(num_chan_p)-1:0]     chan_o,
  output logic [width_p-1:0]               count_o,
  output logic                             busy_o
);

  localparam int                CH_W     = idx_w(num_chan_p);
  localparam int                WIN_W    = idx_w(window_p);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(num_chan_p - 1);
  localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(window_p - 1);

  sched_state_e      r_state, w_state_nxt;
  logic [CH_W-1:0]   r_sel;
  logic [WIN_W-1:0]  r_win;
  logic              w_clear, w_up, w_ev_sel, w_hs;
  logic [width_p-1:0] w_cnt;

  assign w_ev_sel = ev_i[r_sel];
  assign w_hs     = (r_state == ST_REPORT) && ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The event arriving in CLEAR is dropped by holding up low there.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_up        = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (en_i) w_state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        w_up = w_ev_sel;
        if (r_win == '0) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: if (ready_i) w_state_nxt = en_i ? ST_CLEAR : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_win <= '0;
      r_sel <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_win <= WIN_LOAD;
      end else if (r_state == ST_COUNT && r_win != '0) begin
        r_win <= r_win - 1'b1;
      end
      if (w_hs) begin
        r_sel <= (r_sel == CH_LAST) ? '0 : r_sel + 1'b1;
      end
    end
  end

  bsg_counter_clear_up_sat_async #(.width_p(width_p)) u_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .up_i      (w_up),
    .count_o   (w_cnt)
  );

  // Counter is frozen in REPORT, so count_o is stable until the handshake.
  assign v_o     = (r_state == ST_REPORT);
  assign busy_o  = (r_state != ST_IDLE);
  assign chan_o  = r_sel;
  assign count_o = w_cnt;

endmodule

// File: tb/tb_bsg_counter_window_sched.sv
// Scoreboard bench for bsg_counter_window_sched: a procedural window model
// predicts reports, a negedge monitor compares what the DUT presents.
module tb_bsg_counter_window_sched;

  localparam int NCH  = 4;
  localparam int WID  = 8;
  localparam int WIN  = 128;
  localparam int MAXC = (1 << WID) - 1;
  localparam int WID2 = 4;
  localparam int WIN2 = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en, ready, v, busy;
  logic [NCH-1:0] ev;
  logic [1:0]     chan;
  logic [WID-1:0] count;

  logic            en2, ready2, v2, busy2;
  logic [NCH-1:0]  ev2;
  logic [1:0]      chan2;
  logic [WID2-1:0] count2;

  typedef struct { int ch; int cnt; longint rise; } exp_t;
  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  bit     model_on = 0;
  bit     in_rep = 0;
  bit     exp_idle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bsg_counter_window_sched #(.num_chan_p(NCH), .width_p(WID), .window_p(WIN)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .ev_i(ev), .v_o(v),
    .ready_i(ready), .chan_o(chan), .count_o(count), .busy_o(busy)
  );

  bsg_counter_window_sched #(.num_chan_p(NCH), .width_p(WID2), .window_p(WIN2)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en2), .ev_i(ev2), .v_o(v2),
    .ready_i(ready2), .chan_o(chan2), .count_o(count2), .busy_o(busy2)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input int budget);
    int n = 0;
    while (!v && n < budget) begin step(); n++; end
    if (!v) chk("wait_v_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  // Reference model: one window = CLEAR cycle, then WIN counted cycles of the
  // current channel, then a report held until ready; channels rotate mod NCH.
  initial begin : model
    int ch, sum;
    bit go;
    wait (model_on);
    ch = 0;
    go = 0;
    forever begin
      if (!go) begin
        @(negedge clk);
        while (!en) @(negedge clk);
      end
      @(negedge clk);
      sum = 0;
      repeat (WIN) begin
        @(negedge clk);
        sum += int'(ev[ch]);
      end
      sb.push_back('{ch: ch, cnt: (sum > MAXC) ? MAXC : sum, rise: cyc + 1});
      @(negedge clk);
      while (!ready) @(negedge clk);
      ch = (ch + 1) % NCH;
      go = en;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      if (exp_idle) begin
        chk("idle_after_drop_busy", busy, 0);
        exp_idle = 0;
      end
      if (v) begin
        if (sb.size() == 0) begin
          chk("unexpected_report", 1, 0);
        end else begin
          if (!in_rep) chk("v_rise_cycle", cyc, sb[0].rise);
          chk("chan", chan, sb[0].ch);
          chk("count", count, sb[0].cnt);
        end
        in_rep = 1;
        if (ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          in_rep = 0;
          if (!en) exp_idle = 1;
        end
      end
    end
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; en = 0; ready = 0; ev = '0;
    en2 = 0; ready2 = 0; ev2 = '0;
    #1;
    chk("rst_v", v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_chan", chan, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Complete one window, then reset asynchronously mid-way through the next.
    en = 1; ready = 1;
    wait_v(200);
    step();
    ev = 4'b1111;
    repeat (60) step();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_v", v, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_chan", chan, 0);
    en = 0; ev = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_on = 1;

    // Saturation on the narrow instance.
    en2 = 1; ev2 = 4'b1111; ready2 = 1;
    n = 0;
    while (!v2 && n < 60) begin step(); n++; end
    chk("sat_rise_latency", n, WIN2 + 2);
    chk("sat_count", count2, (WIN2 > (1 << WID2) - 1) ? (1 << WID2) - 1 : WIN2);
    chk("sat_chan", chan2, 0);
    en2 = 0;
    step();
    chk("sat_idle_busy", busy2, 0);

    // Full window on channel 0, with enable dropped during CLEAR.
    ev = 4'b0001; ready = 1; en = 1;
    step();
    en = 0;
    wait_idle(300);

    // Boundary pulses: CLEAR (dropped), first COUNT, last COUNT.
    en = 1; ready = 1; ev = '0;
    wait_v(300);
    step(); ev = 4'b1111;
    step(); ev = 4'b1111;
    step(); ev = '0;
    repeat (WIN - 2) step();
    ev = 4'b1111;
    step(); ev = '0;
    en = 0;
    wait_idle(300);

    // Backpressure with toggling events.
    en = 1; ready = 0; ev = 4'($urandom);
    wait_v(300);
    repeat (10) begin step(); ev = 4'($urandom); end
    ready = 1;
    step();
    en = 0;
    wait_idle(300);

    // Round-robin wrap with a fixed pattern.
    en = 1; ready = 1; ev = 4'b1010;
    repeat (5 * (WIN + 2) + 2) step();
    en = 0;
    wait_idle(300);

    // Randomized traffic.
    repeat (1500) begin
      en    = ($urandom % 8) != 0;
      ready = ($urandom % 3) != 0;
      ev    = 4'($urandom);
      step();
    end
    en = 0; ready = 1;
    wait_idle(400);
    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
